// File: rtl/arbitro_memoria.sv
`timescale 1ns/1ps
// Arbiter for the shared instruction/data memory: serialises fetch and
// load/store accesses, drives the memory port and raises PC enable / stall.
module arbitro_memoria #(
  parameter int unsigned LARGURA   = 32,
  parameter int unsigned LATENCIA  = 1,
  parameter int unsigned MAX_DADOS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_busca,
  input  logic [LARGURA-1:0] end_busca,
  input  logic               req_dados,
  input  logic               dados_escrita,
  input  logic [LARGURA-1:0] end_dados,
  input  logic [LARGURA-1:0] valor_dados,
  input  logic [LARGURA-1:0] mem_saida,
  output logic [LARGURA-1:0] mem_endereco,
  output logic [LARGURA-1:0] mem_valor,
  output logic               mem_ler,
  output logic               mem_escreve,
  output logic [LARGURA-1:0] instrucao,
  output logic               instr_valida,
  output logic [LARGURA-1:0] dado_lido,
  output logic               dado_valido,
  output logic               PCescreve,
  output logic               parar_pipeline,
  output logic               ocupado
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    DADOS  = 2'd2
  } estado_t;

  localparam int unsigned LCNT = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  localparam int unsigned LSEQ = $clog2(MAX_DADOS + 1);
  localparam logic [LCNT-1:0] CNT_FIM = LCNT'(LATENCIA - 1);
  localparam logic [LSEQ-1:0] SEQ_MAX = LSEQ'(MAX_DADOS);

  estado_t         estado;
  logic [LCNT-1:0] cnt;
  logic [LSEQ-1:0] sequencia;

  logic concluiu;
  logic arbitra;
  logic dar_dados;
  logic dar_busca;

  assign concluiu  = (estado != OCIOSO) && (cnt == CNT_FIM);
  assign arbitra   = (estado == OCIOSO) || concluiu;
  // Data wins unless a fetch has waited through MAX_DADOS data grants.
  assign dar_dados = req_dados && (!req_busca || (sequencia < SEQ_MAX));
  assign dar_busca = req_busca && !dar_dados;

  assign PCescreve      = instr_valida;
  assign parar_pipeline = req_dados & ~dado_valido;
  assign ocupado        = (estado != OCIOSO);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      sequencia    <= '0;
      mem_endereco <= '0;
      mem_valor    <= '0;
      mem_ler      <= 1'b0;
      mem_escreve  <= 1'b0;
      instrucao    <= '0;
      instr_valida <= 1'b0;
      dado_lido    <= '0;
      dado_valido  <= 1'b0;
    end else begin
      instr_valida <= 1'b0;
      dado_valido  <= 1'b0;

      if (concluiu) begin
        if (estado == BUSCA) begin
          instrucao    <= mem_saida;
          instr_valida <= 1'b1;
        end else begin
          if (!mem_escreve) dado_lido <= mem_saida;
          dado_valido <= 1'b1;
        end
      end else if (estado != OCIOSO) begin
        cnt <= cnt + 1'b1;
      end

      // Completion edge doubles as the next grant edge, so accesses chain without a bubble.
      if (arbitra) begin
        cnt <= '0;
        if (dar_dados) begin
          estado       <= DADOS;
          mem_endereco <= end_dados;
          mem_ler      <= !dados_escrita;
          mem_escreve  <= dados_escrita;
          if (dados_escrita) mem_valor <= valor_dados;
          if (req_busca) sequencia <= sequencia + 1'b1;
        end else if (dar_busca) begin
          estado       <= BUSCA;
          mem_endereco <= end_busca;
          mem_ler      <= 1'b1;
          mem_escreve  <= 1'b0;
          sequencia    <= '0;
        end else begin
          estado      <= OCIOSO;
          mem_ler     <= 1'b0;
          mem_escreve <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
`timescale 1ns/1ps
// Scoreboard bench for arbitro_memoria: two instances (LATENCIA 1 and 3) share
// stimulus; a transaction-level model predicts strobes and completion pulses.
module tb_arbitro_memoria;

  localparam int LAT0  = 1;
  localparam int LAT1  = 3;
  localparam int MAX_D = 4;

  localparam int T_BUSCA = 0;
  localparam int T_LOAD  = 1;
  localparam int T_STORE = 2;

  typedef struct {
    int          inicio;
    int          fim;
    int          tipo;
    logic [31:0] ender;
    logic [31:0] valor;
  } strobe_t;

  typedef struct {
    int          ciclo;
    int          tipo;
    logic [31:0] dado;
  } concl_t;

  logic        clock;
  logic        rst;
  logic        rb;
  logic [31:0] eb;
  logic        rd;
  logic        dw;
  logic [31:0] ed;
  logic [31:0] vd;

  logic [31:0] m_saida [2];
  logic [31:0] o_end   [2];
  logic [31:0] o_val   [2];
  logic [31:0] o_instr [2];
  logic [31:0] o_dado  [2];
  logic        o_ler   [2];
  logic        o_esc   [2];
  logic        o_iv    [2];
  logic        o_dv    [2];
  logic        o_pc    [2];
  logic        o_par   [2];
  logic        o_ocp   [2];

  strobe_t     sq [2][$];
  concl_t      cq [2][$];
  int          streak   [2];
  int          next_arb [2];
  logic [31:0] ult_load [2];

  int cyc      = 0;
  int rst_edge = -1;
  bit armed    = 0;
  int n_cmp    = 0;
  int n_err    = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h4)  return 32'h8C010000;
    if (a == 32'h10) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  assign m_saida[0] = memf(o_end[0]);
  assign m_saida[1] = memf(o_end[1]);

  arbitro_memoria #(.LARGURA(32), .LATENCIA(LAT0), .MAX_DADOS(MAX_D)) dut0 (
    .clock(clock), .reset(rst),
    .req_busca(rb), .end_busca(eb),
    .req_dados(rd), .dados_escrita(dw), .end_dados(ed), .valor_dados(vd),
    .mem_saida(m_saida[0]),
    .mem_endereco(o_end[0]), .mem_valor(o_val[0]),
    .mem_ler(o_ler[0]), .mem_escreve(o_esc[0]),
    .instrucao(o_instr[0]), .instr_valida(o_iv[0]),
    .dado_lido(o_dado[0]), .dado_valido(o_dv[0]),
    .PCescreve(o_pc[0]), .parar_pipeline(o_par[0]), .ocupado(o_ocp[0])
  );

  arbitro_memoria #(.LARGURA(32), .LATENCIA(LAT1), .MAX_DADOS(MAX_D)) dut1 (
    .clock(clock), .reset(rst),
    .req_busca(rb), .end_busca(eb),
    .req_dados(rd), .dados_escrita(dw), .end_dados(ed), .valor_dados(vd),
    .mem_saida(m_saida[1]),
    .mem_endereco(o_end[1]), .mem_valor(o_val[1]),
    .mem_ler(o_ler[1]), .mem_escreve(o_esc[1]),
    .instrucao(o_instr[1]), .instr_valida(o_iv[1]),
    .dado_lido(o_dado[1]), .dado_valido(o_dv[1]),
    .PCescreve(o_pc[1]), .parar_pipeline(o_par[1]), .ocupado(o_ocp[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic verif(input string nome, input int u, input logic [31:0] atual,
                       input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s u%0d cyc %0d: got %h expected %h", nome, u, cyc, atual, esperado);
    end
  endtask

  // Reference: each grant occupies LATENCIA strobe cycles and pulses valid
  // in the cycle right after the last strobe, which is also the next arbitration.
  task automatic modelo(input int u);
    int          k;
    int          lat;
    int          tipo;
    logic [31:0] ender;
    strobe_t     s;
    concl_t      c;
    k    = cyc;
    lat  = (u == 0) ? LAT0 : LAT1;
    tipo = -1;
    ender = '0;
    if (rst) begin
      sq[u].delete();
      cq[u].delete();
      streak[u]   = 0;
      next_arb[u] = k + 1;
      ult_load[u] = '0;
      rst_edge    = k;
      armed       = 1;
    end else if (armed && k >= next_arb[u]) begin
      if (rd && (!rb || streak[u] < MAX_D)) begin
        if (rb) streak[u]++;
        tipo  = dw ? T_STORE : T_LOAD;
        ender = ed;
      end else if (rb) begin
        streak[u] = 0;
        tipo      = T_BUSCA;
        ender     = eb;
      end
      if (tipo < 0) begin
        next_arb[u] = k + 1;
      end else begin
        s.inicio = k;
        s.fim    = k + lat - 1;
        s.tipo   = tipo;
        s.ender  = ender;
        s.valor  = vd;
        c.ciclo  = k + lat;
        c.tipo   = tipo;
        if (tipo == T_STORE) c.dado = ult_load[u];
        else                 c.dado = memf(ender);
        if (tipo == T_LOAD) ult_load[u] = c.dado;
        sq[u].push_back(s);
        cq[u].push_back(c);
        next_arb[u] = k + lat;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      for (int u = 0; u < 2; u++) modelo(u);
    end
  end

  task automatic monitor(input int u);
    strobe_t s;
    concl_t  c;
    logic    e_ler;
    logic    e_esc;
    logic    e_iv;
    logic    e_dv;
    e_ler = 1'b0;
    e_esc = 1'b0;
    e_iv  = 1'b0;
    e_dv  = 1'b0;
    if (rst_edge == cyc) begin
      verif("rst_endereco", u, o_end[u], 32'h0);
      verif("rst_valor", u, o_val[u], 32'h0);
      verif("rst_instrucao", u, o_instr[u], 32'h0);
      verif("rst_dado_lido", u, o_dado[u], 32'h0);
    end
    if (sq[u].size() > 0 && sq[u][0].inicio <= cyc) begin
      s     = sq[u][0];
      e_ler = (s.tipo != T_STORE);
      e_esc = (s.tipo == T_STORE);
      verif("mem_endereco", u, o_end[u], s.ender);
      if (s.tipo == T_STORE) verif("mem_valor", u, o_val[u], s.valor);
      if (s.fim == cyc) void'(sq[u].pop_front());
    end
    verif("mem_ler", u, 32'(o_ler[u]), 32'(e_ler));
    verif("mem_escreve", u, 32'(o_esc[u]), 32'(e_esc));
    verif("ocupado", u, 32'(o_ocp[u]), 32'(e_ler | e_esc));
    while (cq[u].size() > 0 && cq[u][0].ciclo < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL pulso_perdido u%0d cyc %0d: got none expected pulse at %0d", u, cyc,
               cq[u][0].ciclo);
      void'(cq[u].pop_front());
    end
    if (cq[u].size() > 0 && cq[u][0].ciclo == cyc) begin
      c    = cq[u].pop_front();
      e_iv = (c.tipo == T_BUSCA);
      e_dv = (c.tipo != T_BUSCA);
      if (e_iv) verif("instrucao", u, o_instr[u], c.dado);
      else      verif("dado_lido", u, o_dado[u], c.dado);
    end
    verif("instr_valida", u, 32'(o_iv[u]), 32'(e_iv));
    verif("PCescreve", u, 32'(o_pc[u]), 32'(e_iv));
    verif("dado_valido", u, 32'(o_dv[u]), 32'(e_dv));
    verif("parar_pipeline", u, 32'(o_par[u]), 32'(rd & ~e_dv));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (armed) begin
        for (int u = 0; u < 2; u++) monitor(u);
      end
    end
  end

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst = 1'b1; rb = 1'b0; eb = '0; rd = 1'b0; dw = 1'b0; ed = '0; vd = '0;
    #1;
    repeat (3) passo();
    rst = 1'b0;

    // single fetch at 0x4
    rb = 1'b1; eb = 32'h4;
    passo();
    rb = 1'b0; eb = 32'h100;
    repeat (6) passo();

    // store 0xDEADBEEF at 0x40
    rd = 1'b1; dw = 1'b1; ed = 32'h40; vd = 32'hDEADBEEF;
    passo();
    rd = 1'b0; dw = 1'b0; ed = 32'h44; vd = 32'h0;
    repeat (6) passo();

    // simultaneous load and fetch
    rb = 1'b1; eb = 32'h8; rd = 1'b1; dw = 1'b0; ed = 32'h10;
    passo();
    rd = 1'b0;
    passo();
    rb = 1'b0;
    repeat (8) passo();

    // continuous pressure from both sides: streak limit
    rb = 1'b1; eb = 32'h20; rd = 1'b1; dw = 1'b0; ed = 32'h30;
    repeat (40) passo();
    rb = 1'b0; rd = 1'b0;
    repeat (8) passo();

    // load at 0x10
    rd = 1'b1; dw = 1'b0; ed = 32'h10;
    passo();
    rd = 1'b0;
    repeat (6) passo();

    // reset during the second strobe cycle of a fetch
    rb = 1'b1; eb = 32'h4;
    passo();
    rb = 1'b0;
    passo();
    rst = 1'b1;
    passo();
    rst = 1'b0;
    repeat (6) passo();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) rb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) rd = ($urandom_range(0, 3) != 0);
      dw  = $urandom_range(0, 1) == 1;
      eb  = 32'($urandom_range(0, 15)) << 2;
      ed  = 32'($urandom_range(0, 15)) << 2;
      vd  = $urandom;
      rst = ($urandom_range(0, 59) == 0);
      passo();
    end

    rst = 1'b0; rb = 1'b0; rd = 1'b0;
    repeat (10) passo();
    @(negedge clock);
    #1;
    for (int u = 0; u < 2; u++) begin
      verif("fila_strobe_vazia", u, 32'(sq[u].size()), 32'h0);
      verif("fila_conclusao_vazia", u, 32'(cq[u].size()), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Sequences the single shared instruction/data memory (memoriaBloco) between two requesters: the fetch path (PC address) and the data path (ALU address for load/store).
- Replaces the static c1/c2 select and the ler/escreve wiring with a registered arbiter FSM that owns the memory port.
- Generates the PC write enable and a pipeline stall, so structural hazards on the shared memory are resolved in hardware.

Parameters:
- LARGURA, 32, width of addresses and data words
- LATENCIA, 1, memory access cycles per transfer (legal range 1..4)
- MAX_DADOS, 4, max consecutive data grants while a fetch is pending before fetch is forced

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_busca  in  1  fetch request, level; held until instr_valida
- end_busca  in  LARGURA  fetch address (PC); stable while req_busca
- req_dados  in  1  data request, level; held until dado_valido
- dados_escrita  in  1  1 = store, 0 = load; stable while req_dados
- end_dados  in  LARGURA  data address (ALU result)
- valor_dados  in  LARGURA  store data
- mem_saida  in  LARGURA  memory read data
- mem_endereco  out  LARGURA  memory address, registered
- mem_valor  out  LARGURA  memory write data, registered
- mem_ler  out  1  memory read strobe, registered
- mem_escreve  out  1  memory write strobe, registered
- instrucao  out  LARGURA  captured instruction word
- instr_valida  out  1  one-cycle pulse when instrucao is updated
- dado_lido  out  LARGURA  captured load data
- dado_valido  out  1  one-cycle pulse when a load or store completes
- PCescreve  out  1  PC enable; equals instr_valida
- parar_pipeline  out  1  combinational: req_dados & ~dado_valido
- ocupado  out  1  high while an access is in flight

Behaviour:
- Reset (synchronous, active-high): state OCIOSO; all outputs 0; cycle counter and data-streak counter 0.
- States:
  - OCIOSO: no access in flight; mem_ler = mem_escreve = 0; mem_endereco and mem_valor hold their last values.
  - BUSCA: fetch access in flight.
  - DADOS: data access in flight.
- Arbitration runs in OCIOSO and on the completion edge of any access.
  - If req_dados and req_busca are both pending and streak < MAX_DADOS: grant data and increment the streak.
  - Only req_dados pending: grant data; streak unchanged.
  - Only req_busca pending, or streak == MAX_DADOS with req_busca pending: grant fetch and clear the streak to 0.
  - No request pending: go to OCIOSO.
- Grant edge loads the memory registers:
  - Fetch: mem_endereco = end_busca, mem_ler = 1.
  - Load: mem_endereco = end_dados, mem_ler = 1.
  - Store: mem_endereco = end_dados, mem_valor = valor_dados, mem_escreve = 1.
- The strobe stays asserted for exactly LATENCIA cycles. The counter counts 0..LATENCIA-1.
- Completion edge is the edge ending the last strobe cycle.
  - Fetch: instrucao <= mem_saida.
  - Load: dado_lido <= mem_saida.
  - Store: dado_lido unchanged.
  - The matching valid pulse is high for the following single cycle.
- Timing:
  - Latency from request seen in OCIOSO (cycle 0) to valid pulse is LATENCIA+1 cycles (2 at default).
  - Back-to-back accesses have no bubble: the next grant's strobe cycle coincides with the previous valid-pulse cycle.
- Never drive mem_ler and mem_escreve high simultaneously.
- ocupado = (state != OCIOSO).
- A request deasserted mid-access does not cancel the access; the valid pulse still occurs and the requester ignores it.
- Reset asserted mid-access aborts the access. No valid pulse is issued, and strobes are 0 from the next cycle.
- Address/data inputs changing after the grant do not affect the in-flight access (registered copy).

Test Plan:
1. Reset, then req_busca=1, end_busca=0x00000004, mem_saida=0x8C010000, LATENCIA=1 -> mem_ler=1, mem_endereco=0x4 in cycle 1; instr_valida=PCescreve=1 and instrucao=0x8C010000 in cycle 2 only.
2. req_dados=1, dados_escrita=1, end_dados=0x40, valor_dados=0xDEADBEEF -> mem_escreve=1, mem_valor=0xDEADBEEF for one cycle; dado_valido pulses; dado_lido unchanged; parar_pipeline high until the pulse.
3. req_busca and req_dados both asserted in the same cycle -> data granted first (mem_escreve or load at end_dados); fetch granted on the data completion edge with no idle cycle; both valid pulses on consecutive accesses.
4. req_dados held continuously with req_busca pending, MAX_DADOS=4 -> grants in the order D,D,D,D,B,D,D,D,D,B; instr_valida after every 4 data completions.
5. LATENCIA=3, load at 0x10 returning 0x12345678 -> mem_ler high for exactly 3 cycles; dado_valido in cycle 4; dado_lido=0x12345678.
6. reset asserted during the second strobe cycle of a LATENCIA=3 fetch -> next cycle: all outputs 0, state OCIOSO, no instr_valida pulse.
